id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register and execute-operand selection for the 5-stage MIPS pipeline.
- Captures decode-stage control and data each cycle.
- Resolves EX-stage forwarding from MEM and WB.
- Drives SrcA/SrcB/ALUControl straight into the ALU.
- Detects load-use hazards and reports them to the fetch/decode stall logic.

Parameters:
SIZE, 31, MSB index of the datapath word (word width SIZE+1)
REGW, 5, register-specifier width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall_e  in  1  hold ID/EX register contents
flush_e  in  1  load a bubble into ID/EX
reg_write_d  in  1  decode RegWrite
mem_to_reg_d  in  1  decode MemtoReg
mem_write_d  in  1  decode MemWrite
alu_control_d  in  3  decode ALU op code
alu_src_d  in  1  1 = immediate operand B
reg_dst_d  in  1  1 = write rd, 0 = write rt
rd1_d  in  SIZE+1  register-file read data A
rd2_d  in  SIZE+1  register-file read data B
sign_imm_d  in  SIZE+1  sign-extended immediate
rs_d  in  REGW  rs specifier
rt_d  in  REGW  rt specifier
rd_d  in  REGW  rd specifier
alu_out_m  in  SIZE+1  MEM-stage ALU result
reg_write_m  in  1  MEM-stage RegWrite
write_reg_m  in  REGW  MEM-stage destination
result_w  in  SIZE+1  WB-stage result
reg_write_w  in  1  WB-stage RegWrite
write_reg_w  in  REGW  WB-stage destination
src_a_e  out  SIZE+1  ALU operand A
src_b_e  out  SIZE+1  ALU operand B
alu_control_e  out  3  ALU op code
write_data_e  out  SIZE+1  forwarded rt value for stores
write_reg_e  out  REGW  EX destination register
reg_write_e  out  1  registered RegWrite
mem_to_reg_e  out  1  registered MemtoReg
mem_write_e  out  1  registered MemWrite
lw_stall  out  1  load-use hazard detected this cycle

Behaviour:
Register update (all on rising clk):
- reset=1: every registered field cleared to 0. Controls, data and specifiers all 0.
- Else if flush_e=1: all fields cleared to 0 (bubble). Flush takes priority over stall_e.
- Else if stall_e=1: all fields hold.
- Else: all *_d inputs captured.
- Latency: decode inputs appear on the registered outputs one cycle after capture.

Outputs while reset is held:
- Registered outputs read 0.
- With mem_to_reg_e=0, lw_stall reads 0.
- src_a_e, src_b_e and write_data_e read 0 unless forwarding is active (see below).

Forwarding (combinational from registered rs_e/rt_e and live M/W inputs):
- fwd_a = MEM if rs_e≠0 and reg_write_m and write_reg_m==rs_e.
- Else fwd_a = WB if rs_e≠0 and reg_write_w and write_reg_w==rs_e.
- Else fwd_a = RF.
- fwd_b uses the same rule with rt_e.
- MEM beats WB when both match. Register 0 is never forwarded.
- src_a_e = mux(fwd_a: rd1_e / result_w / alu_out_m).
- write_data_e = mux(fwd_b: rd2_e / result_w / alu_out_m).
- src_b_e = alu_src_e ? sign_imm_e : write_data_e.

Destination and pass-through:
- write_reg_e = reg_dst_e ? rd_e : rt_e.
- alu_control_e, reg_write_e, mem_to_reg_e and mem_write_e are direct register outputs.

Load-use detection:
- lw_stall = mem_to_reg_e & ((rs_d==rt_e) | (rt_d==rt_e)). Combinational.
- External hazard logic turns lw_stall into a stall of F/D and flush_e.
- This block does not feed lw_stall back internally.

Other rules:
- A bubble has reg_write_e=0 and mem_write_e=0, so it never forwards or writes.
- No arithmetic is performed; widths are preserved exactly.

Decomposition:
- Shared package: forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, plus the ALU op-code constants (AND=0, OR=1, ADD=2, ANDN=4, ORN=5, SUB=6, SLT=7).
- One sub-module, fwd_unit: pure combinational compare producing fwd_a/fwd_b. It is instantiated once here and is reusable by a later branch-compare forwarder in decode.

Test Plan:
1. Reset and capture: assert reset with nonzero *_d -> all registered outputs 0. Deassert, rd1_d=5, rd2_d=7, alu_src_d=0, alu_control_d=2 -> next cycle src_a_e=5, src_b_e=7, alu_control_e=2.
2. MEM forward: rs_e=8; reg_write_m=1, write_reg_m=8, alu_out_m=0x100 -> src_a_e=0x100. Add reg_write_w=1, write_reg_w=8, result_w=0x200 -> src_a_e stays 0x100 (MEM priority).
3. $0 guard: rt_e=0, reg_write_m=1, write_reg_m=0, alu_out_m=0xFFFF, rd2_e=0 -> write_data_e=0.
4. Immediate with store forward: alu_src_e=1, sign_imm_e=0xFFFFFFFC, rt_e=9 forwarded from WB with result_w=0x33 -> src_b_e=0xFFFFFFFC, write_data_e=0x33.
5. Load-use: mem_to_reg_e=1, rt_e=4, rs_d=4 -> lw_stall=1. Change rs_d=3, rt_d=5 -> lw_stall=0.
6. Stall/flush: stall_e=1 for 2 cycles with changing *_d -> outputs unchanged. Then stall_e=1 and flush_e=1 together -> reg_write_e=mem_write_e=0 and all fields 0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX stage and its forwarding unit.
// The forwarding-priority helper lives here so a decode-side forwarder can reuse it.
package id_ex_stage_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_AND  = 3'd0;
    localparam alu_op_t ALU_OR   = 3'd1;
    localparam alu_op_t ALU_ADD  = 3'd2;
    localparam alu_op_t ALU_ANDN = 3'd4;
    localparam alu_op_t ALU_ORN  = 3'd5;
    localparam alu_op_t ALU_SUB  = 3'd6;
    localparam alu_op_t ALU_SLT  = 3'd7;

    typedef struct packed {
        logic    reg_write;
        logic    mem_to_reg;
        logic    mem_write;
        alu_op_t alu_control;
        logic    alu_src;
        logic    reg_dst;
    } ex_ctrl_t;

    localparam ex_ctrl_t CTRL_BUBBLE = '0;

    // MEM holds the younger result, so it wins over WB; $0 is hard-wired and never forwarded.
    function automatic fwd_sel_t fwd_select(logic src_nonzero, logic hit_m, logic hit_w);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (src_nonzero && hit_m) begin
            sel = FWD_MEM;
        end else if (src_nonzero && hit_w) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode, forwarding-source and execute-operand signals of the ID/EX stage.
// The master drives decode/MEM/WB inputs; the stage (slave) drives the EX outputs.
interface id_ex_stage_if #(
    parameter int unsigned SIZE = 31,
    parameter int unsigned REGW = 5
);
    import id_ex_stage_pkg::*;

    logic            stall_e;
    logic            flush_e;

    logic            reg_write_d;
    logic            mem_to_reg_d;
    logic            mem_write_d;
    alu_op_t         alu_control_d;
    logic            alu_src_d;
    logic            reg_dst_d;
    logic [SIZE:0]   rd1_d;
    logic [SIZE:0]   rd2_d;
    logic [SIZE:0]   sign_imm_d;
    logic [REGW-1:0] rs_d;
    logic [REGW-1:0] rt_d;
    logic [REGW-1:0] rd_d;

    logic [SIZE:0]   alu_out_m;
    logic            reg_write_m;
    logic [REGW-1:0] write_reg_m;
    logic [SIZE:0]   result_w;
    logic            reg_write_w;
    logic [REGW-1:0] write_reg_w;

    logic [SIZE:0]   src_a_e;
    logic [SIZE:0]   src_b_e;
    alu_op_t         alu_control_e;
    logic [SIZE:0]   write_data_e;
    logic [REGW-1:0] write_reg_e;
    logic            reg_write_e;
    logic            mem_to_reg_e;
    logic            mem_write_e;
    logic            lw_stall;

    modport master (
        output stall_e, flush_e,
        output reg_write_d, mem_to_reg_d, mem_write_d, alu_control_d, alu_src_d, reg_dst_d,
        output rd1_d, rd2_d, sign_imm_d, rs_d, rt_d, rd_d,
        output alu_out_m, reg_write_m, write_reg_m, result_w, reg_write_w, write_reg_w,
        input  src_a_e, src_b_e, alu_control_e, write_data_e, write_reg_e,
        input  reg_write_e, mem_to_reg_e, mem_write_e, lw_stall
    );

    modport slave (
        input  stall_e, flush_e,
        input  reg_write_d, mem_to_reg_d, mem_write_d, alu_control_d, alu_src_d, reg_dst_d,
        input  rd1_d, rd2_d, sign_imm_d, rs_d, rt_d, rd_d,
        input  alu_out_m, reg_write_m, write_reg_m, result_w, reg_write_w, write_reg_w,
        output src_a_e, src_b_e, alu_control_e, write_data_e, write_reg_e,
        output reg_write_e, mem_to_reg_e, mem_write_e, lw_stall
    );

endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// Combinational forwarding-source selection for two source registers against the
// MEM and WB destinations.
module id_ex_stage_fwd_unit
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned REGW = 5
) (
    input  logic [REGW-1:0] rs_e_i,
    input  logic [REGW-1:0] rt_e_i,
    input  logic            reg_write_m_i,
    input  logic [REGW-1:0] write_reg_m_i,
    input  logic            reg_write_w_i,
    input  logic [REGW-1:0] write_reg_w_i,
    output fwd_sel_t        fwd_a_o,
    output fwd_sel_t        fwd_b_o
);

    logic hit_a_m, hit_a_w, hit_b_m, hit_b_w;

    always_comb begin
        hit_a_m = reg_write_m_i && (write_reg_m_i == rs_e_i);
        hit_a_w = reg_write_w_i && (write_reg_w_i == rs_e_i);
        hit_b_m = reg_write_m_i && (write_reg_m_i == rt_e_i);
        hit_b_w = reg_write_w_i && (write_reg_w_i == rt_e_i);

        fwd_a_o = fwd_select(rs_e_i != '0, hit_a_m, hit_a_w);
        fwd_b_o = fwd_select(rt_e_i != '0, hit_b_m, hit_b_w);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use detection.
// Operand muxes are combinational from the registered specifiers and live MEM/WB buses.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned SIZE = 31,
    parameter int unsigned REGW = 5
) (
    input logic         clk,
    input logic         reset,
    id_ex_stage_if.slave bus
);

    ex_ctrl_t        ctrl_q, ctrl_d;
    logic [SIZE:0]   rd1_q, rd1_d;
    logic [SIZE:0]   rd2_q, rd2_d;
    logic [SIZE:0]   imm_q, imm_d;
    logic [REGW-1:0] rs_q, rs_d;
    logic [REGW-1:0] rt_q, rt_d;
    logic [REGW-1:0] rd_q, rd_d;

    fwd_sel_t        fwd_a, fwd_b;
    logic [SIZE:0]   src_a;
    logic [SIZE:0]   write_data;

    // Flush beats stall so a stalled slot can still be turned into a bubble.
    always_comb begin
        ctrl_d = ctrl_q;
        rd1_d  = rd1_q;
        rd2_d  = rd2_q;
        imm_d  = imm_q;
        rs_d   = rs_q;
        rt_d   = rt_q;
        rd_d   = rd_q;
        if (bus.flush_e) begin
            ctrl_d = CTRL_BUBBLE;
            rd1_d  = '0;
            rd2_d  = '0;
            imm_d  = '0;
            rs_d   = '0;
            rt_d   = '0;
            rd_d   = '0;
        end else if (!bus.stall_e) begin
            ctrl_d.reg_write   = bus.reg_write_d;
            ctrl_d.mem_to_reg  = bus.mem_to_reg_d;
            ctrl_d.mem_write   = bus.mem_write_d;
            ctrl_d.alu_control = bus.alu_control_d;
            ctrl_d.alu_src     = bus.alu_src_d;
            ctrl_d.reg_dst     = bus.reg_dst_d;
            rd1_d              = bus.rd1_d;
            rd2_d              = bus.rd2_d;
            imm_d              = bus.sign_imm_d;
            rs_d               = bus.rs_d;
            rt_d               = bus.rt_d;
            rd_d               = bus.rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= CTRL_BUBBLE;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            imm_q  <= imm_d;
            rs_q   <= rs_d;
            rt_q   <= rt_d;
            rd_q   <= rd_d;
        end
    end

    id_ex_stage_fwd_unit #(
        .REGW (REGW)
    ) u_fwd_unit (
        .rs_e_i        (rs_q),
        .rt_e_i        (rt_q),
        .reg_write_m_i (bus.reg_write_m),
        .write_reg_m_i (bus.write_reg_m),
        .reg_write_w_i (bus.reg_write_w),
        .write_reg_w_i (bus.write_reg_w),
        .fwd_a_o       (fwd_a),
        .fwd_b_o       (fwd_b)
    );

    always_comb begin
        case (fwd_a)
            FWD_MEM: src_a = bus.alu_out_m;
            FWD_WB:  src_a = bus.result_w;
            default: src_a = rd1_q;
        endcase
        case (fwd_b)
            FWD_MEM: write_data = bus.alu_out_m;
            FWD_WB:  write_data = bus.result_w;
            default: write_data = rd2_q;
        endcase
    end

    assign bus.src_a_e       = src_a;
    assign bus.write_data_e  = write_data;
    assign bus.src_b_e       = ctrl_q.alu_src ? imm_q : write_data;
    assign bus.write_reg_e   = ctrl_q.reg_dst ? rd_q : rt_q;
    assign bus.alu_control_e = ctrl_q.alu_control;
    assign bus.reg_write_e   = ctrl_q.reg_write;
    assign bus.mem_to_reg_e  = ctrl_q.mem_to_reg;
    assign bus.mem_write_e   = ctrl_q.mem_write;

    // Raised only; the hazard unit decides how to stall and flush.
    assign bus.lw_stall = ctrl_q.mem_to_reg & ((bus.rs_d == rt_q) | (bus.rt_d == rt_q));

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized + directed scoreboard bench for id_ex_stage against a behavioural model.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int unsigned SIZE = 31;
    localparam int unsigned REGW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_stage_if #(.SIZE(SIZE), .REGW(REGW)) bus ();

    id_ex_stage #(.SIZE(SIZE), .REGW(REGW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        reset, stall, flush;
        logic        reg_write, mem_to_reg, mem_write;
        logic [2:0]  alu_control;
        logic        alu_src, reg_dst;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic [31:0] alu_out_m;
        logic        reg_write_m;
        logic [4:0]  write_reg_m;
        logic [31:0] result_w;
        logic        reg_write_w;
        logic [4:0]  write_reg_w;
    } stim_t;

    // What the ID/EX slot currently holds: one decoded instruction.
    typedef struct packed {
        logic        reg_write, mem_to_reg, mem_write;
        logic [2:0]  alu_control;
        logic        alu_src, reg_dst;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
    } slot_t;

    typedef struct packed {
        logic [31:0] src_a, src_b, write_data;
        logic [2:0]  alu_control;
        logic [4:0]  write_reg;
        logic        reg_write, mem_to_reg, mem_write, lw_stall;
    } exp_t;

    int tests  = 0;
    int failed = 0;
    exp_t  exp_q[$];
    stim_t cur;
    slot_t slot;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Value an operand reads: youngest in-flight writer wins, $0 always reads its file value.
    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf,
                                            input stim_t s);
        if (r != 0 && s.reg_write_m && s.write_reg_m == r) return s.alu_out_m;
        if (r != 0 && s.reg_write_w && s.write_reg_w == r) return s.result_w;
        return rf;
    endfunction

    function automatic exp_t expect_of(input slot_t sl, input stim_t s);
        exp_t e;
        e.src_a       = operand(sl.rs, sl.rd1, s);
        e.write_data  = operand(sl.rt, sl.rd2, s);
        e.src_b       = sl.alu_src ? sl.imm : e.write_data;
        e.alu_control = sl.alu_control;
        e.write_reg   = sl.reg_dst ? sl.rd : sl.rt;
        e.reg_write   = sl.reg_write;
        e.mem_to_reg  = sl.mem_to_reg;
        e.mem_write   = sl.mem_write;
        e.lw_stall    = sl.mem_to_reg && (s.rs == sl.rt || s.rt == sl.rt);
        return e;
    endfunction

    task automatic apply(input stim_t s);
        reset              = s.reset;
        bus.stall_e        = s.stall;
        bus.flush_e        = s.flush;
        bus.reg_write_d    = s.reg_write;
        bus.mem_to_reg_d   = s.mem_to_reg;
        bus.mem_write_d    = s.mem_write;
        bus.alu_control_d  = s.alu_control;
        bus.alu_src_d      = s.alu_src;
        bus.reg_dst_d      = s.reg_dst;
        bus.rd1_d          = s.rd1;
        bus.rd2_d          = s.rd2;
        bus.sign_imm_d     = s.imm;
        bus.rs_d           = s.rs;
        bus.rt_d           = s.rt;
        bus.rd_d           = s.rd;
        bus.alu_out_m      = s.alu_out_m;
        bus.reg_write_m    = s.reg_write_m;
        bus.write_reg_m    = s.write_reg_m;
        bus.result_w       = s.result_w;
        bus.reg_write_w    = s.reg_write_w;
        bus.write_reg_w    = s.write_reg_w;
    endtask

    // Advance one clock: the slot takes what was driven before the edge, then new stimulus goes out.
    task automatic drive(input stim_t s);
        @(posedge clk);
        #1;
        if (cur.reset || cur.flush) begin
            slot = '0;
        end else if (!cur.stall) begin
            slot = '{reg_write: cur.reg_write, mem_to_reg: cur.mem_to_reg,
                     mem_write: cur.mem_write, alu_control: cur.alu_control,
                     alu_src: cur.alu_src, reg_dst: cur.reg_dst, rd1: cur.rd1,
                     rd2: cur.rd2, imm: cur.imm, rs: cur.rs, rt: cur.rt, rd: cur.rd};
        end
        cur = s;
        apply(s);
        exp_q.push_back(expect_of(slot, s));
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.reset       = ($urandom_range(0, 31) == 0);
        s.stall       = ($urandom_range(0, 5) == 0);
        s.flush       = ($urandom_range(0, 7) == 0);
        s.reg_write   = 1'($urandom);
        s.mem_to_reg  = 1'($urandom);
        s.mem_write   = 1'($urandom);
        s.alu_control = 3'($urandom);
        s.alu_src     = 1'($urandom);
        s.reg_dst     = 1'($urandom);
        s.rd1         = $urandom;
        s.rd2         = $urandom;
        s.imm         = $urandom;
        s.rs          = 5'($urandom_range(0, 3));
        s.rt          = 5'($urandom_range(0, 3));
        s.rd          = 5'($urandom_range(0, 31));
        s.alu_out_m   = $urandom;
        s.reg_write_m = 1'($urandom);
        s.write_reg_m = 5'($urandom_range(0, 3));
        s.result_w    = $urandom;
        s.reg_write_w = 1'($urandom);
        s.write_reg_w = 5'($urandom_range(0, 3));
        return s;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("src_a_e",       bus.src_a_e,              e.src_a);
            chk("src_b_e",       bus.src_b_e,              e.src_b);
            chk("write_data_e",  bus.write_data_e,         e.write_data);
            chk("alu_control_e", 32'(bus.alu_control_e),   32'(e.alu_control));
            chk("write_reg_e",   32'(bus.write_reg_e),     32'(e.write_reg));
            chk("reg_write_e",   32'(bus.reg_write_e),     32'(e.reg_write));
            chk("mem_to_reg_e",  32'(bus.mem_to_reg_e),    32'(e.mem_to_reg));
            chk("mem_write_e",   32'(bus.mem_write_e),     32'(e.mem_write));
            chk("lw_stall",      32'(bus.lw_stall),        32'(e.lw_stall));
        end
    end

    initial begin
        stim_t s;
        slot = '0;
        cur  = '0;
        cur.reset = 1'b1;
        apply(cur);

        // Reset with busy decode inputs.
        s = '0; s.reset = 1'b1; s.reg_write = 1'b1; s.mem_to_reg = 1'b1; s.mem_write = 1'b1;
        s.alu_control = 3'd7; s.rd1 = 32'hFFFF_FFFF; s.rd2 = 32'h1234; s.rs = 5'd3; s.rt = 5'd3;
        drive(s); drive(s);
        // Plain capture.
        s = '0; s.rd1 = 32'd5; s.rd2 = 32'd7; s.alu_control = ALU_ADD; s.rs = 5'd1; s.rt = 5'd2;
        drive(s);
        // MEM forward on rs=8, then MEM vs WB priority.
        s = '0; s.rs = 5'd8; s.rd1 = 32'h11; drive(s);
        s = '0; s.stall = 1'b1; s.reg_write_m = 1'b1; s.write_reg_m = 5'd8;
        s.alu_out_m = 32'h100; drive(s);
        s.reg_write_w = 1'b1; s.write_reg_w = 5'd8; s.result_w = 32'h200; drive(s);
        // $0 is never forwarded.
        s = '0; s.rt = 5'd0; s.rd2 = 32'd0; drive(s);
        s = '0; s.stall = 1'b1; s.reg_write_m = 1'b1; s.write_reg_m = 5'd0;
        s.alu_out_m = 32'hFFFF; drive(s);
        // Immediate operand B while the store data is forwarded from WB.
        s = '0; s.alu_src = 1'b1; s.imm = 32'hFFFF_FFFC; s.rt = 5'd9; s.mem_write = 1'b1;
        drive(s);
        s = '0; s.stall = 1'b1; s.reg_write_w = 1'b1; s.write_reg_w = 5'd9;
        s.result_w = 32'h33; drive(s);
        // Load-use detection.
        s = '0; s.mem_to_reg = 1'b1; s.reg_write = 1'b1; s.rt = 5'd4; drive(s);
        s = '0; s.stall = 1'b1; s.rs = 5'd4; drive(s);
        s.rs = 5'd3; s.rt = 5'd5; drive(s);
        // Stall holds against changing inputs; flush beats stall.
        s = '0; s.reg_write = 1'b1; s.mem_write = 1'b1; s.rd1 = 32'hA5; s.rs = 5'd6;
        s.rd = 5'd12; s.reg_dst = 1'b1; drive(s);
        for (int i = 0; i < 2; i++) begin
            s = rand_stim(); s.reset = 1'b0; s.flush = 1'b0; s.stall = 1'b1; drive(s);
        end
        s = rand_stim(); s.reset = 1'b0; s.stall = 1'b1; s.flush = 1'b1; drive(s);
        s = rand_stim(); s.reset = 1'b0; s.stall = 1'b1; s.flush = 1'b0; drive(s);

        for (int i = 0; i < 400; i++) begin
            drive(rand_stim());
        end
        s = '0; drive(s);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
